instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Producer side of the instruction-register interface in the multicycle CPU.
- Owns the PC and issues a req/ack read to instruction memory during the control unit's IF state.
- Delivers the captured instruction word, the PC+4 upper nibble and a one-cycle IRWre load strobe to the IR stage.
- Detects the halt opcode and blocks further fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- HALT_OP, 6'b111111, opcode that sets the halted flag.
- TIMEOUT_CYCLES, 16, ack watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  fetch request pulse from the control unit.
- pc_load  in  1  load next PC.
- pc_in  in  32  next PC value; bits [1:0] are forced to 0.
- mem_req  out  1  memory read request.
- mem_addr  out  32  memory read address.
- mem_rdata  in  32  memory read data; valid when mem_ack=1.
- mem_ack  in  1  memory read acknowledge.
- instruction  out  32  captured instruction word.
- PC4  out  4  bits [31:28] of (fetch PC + 4), used for the jump target.
- IRWre  out  1  one-cycle IR load strobe.
- pc  out  32  current PC.
- busy  out  1  high in any state other than IDLE.
- halted  out  1  halt opcode has been fetched.
- fetch_err  out  1  sticky timeout error (optional feature only).

Behaviour:
- Reset (Reset=0, asynchronous) sets:
  - pc=RESET_PC; instruction=0; PC4=0; IRWre=0; mem_req=0; mem_addr=0; busy=0; halted=0; fetch_err=0.
  - pending-load register cleared; FSM to IDLE.
  - Reset mid-fetch abandons the transaction immediately; a late mem_ack after reset is ignored.
- FSM states: IDLE, REQ, CAPTURE.
- IDLE:
  - start=1 and halted=0 -> REQ. The next cycle has mem_req=1 and mem_addr=pc.
  - start while halted is ignored.
- REQ:
  - mem_req and mem_addr held stable until mem_ack.
  - mem_ack=1 sampled -> register instruction<=mem_rdata, PC4<=(pc+4)[31:28], pc<=pc+4, then go to CAPTURE. mem_req drops in that same edge.
  - mem_ack arriving in the same cycle mem_req first rises is legal; the minimum start-to-IRWre latency is 2 cycles.
- CAPTURE:
  - IRWre=1 for exactly this one cycle.
  - If instruction[31:26]==HALT_OP, halted<=1; halted stays set until reset.
  - Next state IDLE.
- pc_load:
  - In IDLE: pc<={pc_in[31:2],2'b00} at the edge.
  - Simultaneous start and pc_load in IDLE: the load wins, and the fetch uses the new PC (mem_addr=pc_in aligned).
  - While busy: value stored in a pending register and applied on entry to IDLE, overriding the pc+4 increment. A second pc_load while pending overwrites the first.
- start while busy is ignored (no queueing).
- mem_ack while not in REQ is ignored.
- PC wrap: 32'hFFFF_FFFC+4 -> 0, modulo 2^32; PC4 uses the wrapped value.
- instruction and PC4 change only on capture; they hold between fetches.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter runs in REQ. If no mem_ack arrives within TIMEOUT_CYCLES cycles of mem_req rising, the unit drops mem_req.
  - It then loads instruction=32'h0000_0000 (NOP), advances pc by 4, pulses IRWre via CAPTURE, and sets fetch_err (sticky until reset).
  - The counter clears on every entry to REQ.
- FETCH_TIMEOUT_EN undefined:
  - No counter; REQ waits indefinitely.
  - fetch_err is tied to 0.

Test Plan:
- Basic fetch: reset, start pulse, mem_ack one cycle after mem_req with rdata 32'h0241_8020 -> mem_addr=0, IRWre pulses once, instruction=32'h0241_8020, pc=4, PC4=0, busy low after CAPTURE.
- Wait states: mem_ack delayed 5 cycles -> mem_req/mem_addr stable for 6 cycles, single IRWre, no double capture.
- PC load race:
  - pc_load with pc_in=32'h1000_0007 together with start in IDLE -> mem_addr=32'h1000_0004.
  - pc_load 32'h0000_0040 during REQ -> after capture pc=0x40, not pc+4.
- Wrap and halt: pc_load 32'hFFFF_FFFC, fetch rdata 32'hFC00_0000 -> pc=0, PC4=0, halted=1; a subsequent start produces no mem_req.
- Async reset mid-REQ: Reset low while mem_req=1 -> all outputs at reset values without a clock edge; late mem_ack produces no IRWre.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=16 and mem_ack never asserted -> mem_req drops after 16 cycles, instruction=0, IRWre pulses once, fetch_err=1, pc advanced by 4.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs a req/ack read to instruction memory and hands the
// captured word to the IR stage. Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP        = 6'b111111,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] instruction,
    output logic [3:0]  PC4,
    output logic        IRWre,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        fetch_err
);

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [1:0] {StIdle, StReq, StCapture} state_e;

    state_e      state;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic [31:0] pc_in_al;
    logic [31:0] pc_inc;
    logic        tmo_hit;

    assign pc_in_al = pc_in & ~32'd3;
    assign pc_inc   = pc + 32'd4;
    assign busy     = (state != StIdle);

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt;
    // Fires on the last of TIMEOUT_CYCLES request cycles without an ack.
    assign tmo_hit = (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state       <= StIdle;
            pc          <= RESET_PC;
            instruction <= '0;
            PC4         <= '0;
            IRWre       <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            halted      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt     <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            IRWre <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (pc_load) begin
                        pc <= pc_in_al;
                    end
                    if (start && !halted) begin
                        state    <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_load ? pc_in_al : pc;
`ifdef FETCH_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                StReq: begin
                    if (pc_load) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= pc_in_al;
                    end
                    if (mem_ack || tmo_hit) begin
                        // A timed-out fetch delivers a NOP so the IR stage still sees one word.
                        instruction <= mem_ack ? mem_rdata : 32'h0000_0000;
                        PC4         <= pc_inc[31:28];
                        pc          <= pc_inc;
                        mem_req     <= 1'b0;
                        IRWre       <= 1'b1;
                        state       <= StCapture;
`ifdef FETCH_TIMEOUT_EN
                        if (!mem_ack) begin
                            fetch_err <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end
                StCapture: begin
                    if (instruction[31:26] == HALT_OP) begin
                        halted <= 1'b1;
                    end
                    // A redirect seen during the fetch overrides the sequential pc+4.
                    if (pc_load) begin
                        pc <= pc_in_al;
                    end else if (pend_valid) begin
                        pc <= pend_pc;
                    end
                    pend_valid <= 1'b0;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; expected values are hand-derived constants.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_in = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instruction;
    logic [3:0]  PC4;
    logic        IRWre;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail = 0;
    int irwre_cnt = 0;
    int base;

    instr_fetch_unit dut (
        .clk         (clk),
        .Reset       (Reset),
        .start       (start),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instruction (instruction),
        .PC4         (PC4),
        .IRWre       (IRWre),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (IRWre === 1'b1) irwre_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pc"}, pc, 32'h0);
        check({tag, ".instr"}, instruction, 32'h0);
        check({tag, ".pc4"}, {28'h0, PC4}, 32'h0);
        check({tag, ".irwre"}, {31'h0, IRWre}, 32'h0);
        check({tag, ".req"}, {31'h0, mem_req}, 32'h0);
        check({tag, ".addr"}, mem_addr, 32'h0);
        check({tag, ".busy"}, {31'h0, busy}, 32'h0);
        check({tag, ".halted"}, {31'h0, halted}, 32'h0);
        check({tag, ".err"}, {31'h0, fetch_err}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] pc_before;

        // Reset
        #2 Reset = 1'b0;
        #1 check_reset_state("rst");
        tick();
        tick();
        Reset = 1'b1;

        // Basic fetch, ack one cycle after mem_req
        start = 1'b1;
        tick();
        start = 1'b0;
        check("basic.req", {31'h0, mem_req}, 32'h1);
        check("basic.addr", mem_addr, 32'h0);
        tick();
        mem_rdata = 32'h0241_8020;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("basic.irwre", {31'h0, IRWre}, 32'h1);
        check("basic.instr", instruction, 32'h0241_8020);
        check("basic.pc", pc, 32'h4);
        check("basic.pc4", {28'h0, PC4}, 32'h0);
        check("basic.req_drop", {31'h0, mem_req}, 32'h0);
        base = irwre_cnt;
        tick();
        check("basic.busy", {31'h0, busy}, 32'h0);
        check("basic.irwre_low", {31'h0, IRWre}, 32'h0);
        check("basic.pulses", irwre_cnt - base, 32'h1);

        // Wait states: ack in the sixth request cycle
        base = irwre_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wait.req0", {31'h0, mem_req}, 32'h1);
        check("wait.addr0", mem_addr, 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait.req", {31'h0, mem_req}, 32'h1);
            check("wait.addr", mem_addr, 32'h4);
            check("wait.irwre", {31'h0, IRWre}, 32'h0);
        end
        mem_rdata = 32'h8C22_0004;
        mem_ack = 1'b1;
        tick();
        check("wait.instr", instruction, 32'h8C22_0004);
        check("wait.pc", pc, 32'h8);
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        mem_ack = 1'b0;
        check("wait.hold_instr", instruction, 32'h8C22_0004);
        check("wait.busy", {31'h0, busy}, 32'h0);
        check("wait.pulses", irwre_cnt - base, 32'h1);

        // pc_load together with start in IDLE
        pc_load = 1'b1;
        pc_in = 32'h1000_0007;
        start = 1'b1;
        tick();
        pc_load = 1'b0;
        start = 1'b0;
        check("race.addr", mem_addr, 32'h1000_0004);
        mem_rdata = 32'h0000_0000;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("race.pc", pc, 32'h1000_0008);
        check("race.pc4", {28'h0, PC4}, 32'h1);
        tick();

        // pc_load during REQ overrides pc+4
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pend.addr", mem_addr, 32'h1000_0008);
        pc_load = 1'b1;
        pc_in = 32'h0000_0040;
        tick();
        pc_load = 1'b0;
        check("pend.pc_hold", pc, 32'h1000_0008);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pend.pc_inc", pc, 32'h1000_000C);
        tick();
        check("pend.pc", pc, 32'h0000_0040);

        // Wrap and halt
        pc_load = 1'b1;
        pc_in = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0;
        check("wrap.pc_load", pc, 32'hFFFF_FFFC);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("wrap.addr", mem_addr, 32'hFFFF_FFFC);
        mem_rdata = 32'hFC00_0000;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("wrap.pc", pc, 32'h0);
        check("wrap.pc4", {28'h0, PC4}, 32'h0);
        check("wrap.instr", instruction, 32'hFC00_0000);
        tick();
        check("halt.halted", {31'h0, halted}, 32'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("halt.no_req", {31'h0, mem_req}, 32'h0);
        check("halt.busy", {31'h0, busy}, 32'h0);
        tick();
        check("halt.sticky", {31'h0, halted}, 32'h1);

        // Async reset mid-REQ
        do_reset();
        check("rst2.halted", {31'h0, halted}, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arst.req", {31'h0, mem_req}, 32'h1);
        base = irwre_cnt;
        #2 Reset = 1'b0;
        #1 check_reset_state("arst");
        #1 Reset = 1'b1;
        mem_rdata = 32'h1234_5678;
        mem_ack = 1'b1;
        tick();
        check("arst.late_irwre", {31'h0, IRWre}, 32'h0);
        check("arst.late_req", {31'h0, mem_req}, 32'h0);
        tick();
        mem_ack = 1'b0;
        check("arst.instr", instruction, 32'h0);
        check("arst.pulses", irwre_cnt - base, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // Ack never arrives: watchdog delivers a NOP
        pc_before = pc;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("tmo.req_cycles", n, 32'd16);
        check("tmo.irwre", {31'h0, IRWre}, 32'h1);
        check("tmo.instr", instruction, 32'h0);
        check("tmo.err", {31'h0, fetch_err}, 32'h1);
        check("tmo.pc", pc, pc_before + 32'd4);
        tick();
        tick();
        check("tmo.err_sticky", {31'h0, fetch_err}, 32'h1);
`else
        // No watchdog: REQ waits indefinitely
        pc_before = pc;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req === 1'b1) n++;
        end
        check("nowd.req_cycles", n, 32'd20);
        check("nowd.err", {31'h0, fetch_err}, 32'h0);
        mem_rdata = 32'h0000_1111;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("nowd.irwre", {31'h0, IRWre}, 32'h1);
        check("nowd.pc", pc, pc_before + 32'd4);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
